// File: rtl/rx_ocm_loader_pkg.sv
// rtl/rx_ocm_loader_pkg.sv - shared types and constants for the OCM-to-DFE loader
package rx_ocm_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_BURST     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_STREAM    = 3'd4,
    ST_DRAIN     = 3'd5,
    ST_FINISH    = 3'd6
  } state_e;

  // Tap word layout inside mem_data[31:0]: {mantissa, shift}
  localparam int TAP_MANT_MSB  = 31;
  localparam int TAP_MANT_LSB  = 16;
  localparam int TAP_SHIFT_MSB = 15;
  localparam int TAP_SHIFT_LSB = 0;

  // Cycles spent in WAIT_DONE before the watchdog gives up
  localparam int WAIT_DONE_TIMEOUT = 64;

  // Samples sit directly after the tap words in OCM
  function automatic int unsigned sample_base_addr(input int unsigned num_taps);
    return num_taps;
  endfunction

endpackage

// File: rtl/rx_ocm_loader_rd_latency_pipe.sv
// rtl/rx_ocm_loader_rd_latency_pipe.sv - tracks {valid, is_sample} of each OCM read until its data returns
module rd_latency_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic is_sample_i,
  output logic valid_o,
  output logic is_sample_o,
  output logic empty_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] sample_q;

  // Shift read tags forward one stage per cycle; reset drops every in-flight read
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      sample_q <= '0;
    end else begin
      valid_q[0]  <= valid_i;
      sample_q[0] <= is_sample_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i]  <= valid_q[i-1];
        sample_q[i] <= sample_q[i-1];
      end
    end
  end

  assign valid_o     = valid_q[DEPTH-1];
  assign is_sample_o = sample_q[DEPTH-1];
  assign empty_o     = ~|valid_q;

endmodule

// File: rtl/rx_ocm_loader.sv
// rtl/rx_ocm_loader.sv - loads DFE taps from OCM then streams samples; RX_OCM_LOADER_TIMEOUT_EN adds a WAIT_DONE watchdog
module rx_ocm_loader
  import rx_ocm_pkg::*;
#(
  parameter int PULSE_RESPONSE_LENGTH = 5,
  parameter int SIGNAL_RESOLUTION     = 8,
  parameter int MEM_ADDR_WIDTH        = 12,
  parameter int NUM_SAMPLES           = 1024,
  parameter int READ_LATENCY          = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         hold_i,
  output logic                         mem_rd_o,
  output logic [MEM_ADDR_WIDTH-1:0]    mem_addr_o,
  input  logic [63:0]                  mem_rdata_i,
  output logic                         load_mem_o,
  output logic [7:0]                   location_o,
  output logic [63:0]                  mem_data_o,
  input  logic                         done_wait_i,
  output logic [SIGNAL_RESOLUTION-1:0] signal_in_o,
  output logic                         signal_in_valid_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o
);

  localparam int CNT_W     = ($clog2(NUM_SAMPLES + 1) > 5) ? $clog2(NUM_SAMPLES + 1) : 5;
  localparam int TAP_IDX_W = $clog2(PULSE_RESPONSE_LENGTH);

  localparam logic [CNT_W-1:0]          TAP_CNT   = CNT_W'(PULSE_RESPONSE_LENGTH);
  localparam logic [CNT_W-1:0]          SMP_CNT   = CNT_W'(NUM_SAMPLES);
  localparam logic [CNT_W-1:0]          SMP_LAST  = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [4:0]                TAP_LAST  = 5'(PULSE_RESPONSE_LENGTH - 1);
  localparam logic [4:0]                K_LAST    = 5'(PULSE_RESPONSE_LENGTH + 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR = MEM_ADDR_WIDTH'(sample_base_addr(PULSE_RESPONSE_LENGTH));

  state_e                         state_q;
  logic                           mem_rd_q;
  logic                           rd_sample_q;
  logic [MEM_ADDR_WIDTH-1:0]      mem_addr_q;
  logic                           load_mem_q;
  logic [7:0]                     location_q;
  logic [63:0]                    mem_data_q;
  logic                           busy_q;
  logic                           done_q;
  logic [CNT_W-1:0]               rd_cnt_q;
  logic [4:0]                     cap_q;
  logic [4:0]                     k_q;
  logic [63:0]                    tap_q [PULSE_RESPONSE_LENGTH];
  logic [SIGNAL_RESOLUTION-1:0]   sig_q;
  logic                           sig_valid_q;

`ifdef RX_OCM_LOADER_TIMEOUT_EN
  localparam logic [6:0] WD_LAST = 7'(WAIT_DONE_TIMEOUT - 1);
  logic [6:0] wd_q;
  logic       error_q;
`endif

  logic                 pipe_valid;
  logic                 pipe_sample;
  logic                 pipe_empty;
  logic [4:0]           k_next;
  logic [4:0]           loc_next;
  logic [TAP_IDX_W-1:0] burst_sel;
  logic [TAP_IDX_W-1:0] cap_sel;

  rd_latency_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_rd_pipe (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (mem_rd_q),
    .is_sample_i (rd_sample_q),
    .valid_o     (pipe_valid),
    .is_sample_o (pipe_sample),
    .empty_o     (pipe_empty)
  );

  // Burst skew: location runs one ahead of the tap word so the DFE lands tap[j] at index j
  always_comb begin
    k_next    = k_q + 5'd1;
    loc_next  = (k_next > TAP_LAST) ? TAP_LAST : k_next;
    burst_sel = (k_q > TAP_LAST) ? TAP_IDX_W'(TAP_LAST) : TAP_IDX_W'(k_q);
    cap_sel   = TAP_IDX_W'(cap_q);
  end

  // Main sequencer with registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mem_rd_q    <= 1'b0;
      rd_sample_q <= 1'b0;
      mem_addr_q  <= '0;
      load_mem_q  <= 1'b0;
      location_q  <= '0;
      mem_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_cnt_q    <= '0;
      cap_q       <= '0;
      k_q         <= '0;
      for (int i = 0; i < PULSE_RESPONSE_LENGTH; i++) tap_q[i] <= '0;
`ifdef RX_OCM_LOADER_TIMEOUT_EN
      wd_q        <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      mem_rd_q    <= 1'b0;
      rd_sample_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            busy_q   <= 1'b1;
            cap_q    <= '0;
            rd_cnt_q <= '0;
`ifdef RX_OCM_LOADER_TIMEOUT_EN
            error_q  <= 1'b0;
`endif
            if (done_wait_i) begin
              // Taps already resident in the DFE: go straight to samples
              state_q <= ST_STREAM;
              if (!hold_i) begin
                mem_rd_q    <= 1'b1;
                rd_sample_q <= 1'b1;
                mem_addr_q  <= BASE_ADDR;
                rd_cnt_q    <= CNT_W'(1);
              end
            end else begin
              state_q    <= ST_FETCH;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= '0;
              rd_cnt_q   <= CNT_W'(1);
            end
          end
        end
        ST_FETCH: begin
          if (rd_cnt_q < TAP_CNT) begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= MEM_ADDR_WIDTH'(rd_cnt_q);
            rd_cnt_q   <= rd_cnt_q + CNT_W'(1);
          end
          if (pipe_valid && !pipe_sample) begin
            tap_q[cap_sel] <= mem_rdata_i;
            if (cap_q == TAP_LAST) begin
              state_q    <= ST_BURST;
              load_mem_q <= 1'b1;
              location_q <= '0;
              mem_data_q <= tap_q[0];
              k_q        <= '0;
              rd_cnt_q   <= '0;
            end else begin
              cap_q <= cap_q + 5'd1;
            end
          end
        end
        ST_BURST: begin
          if (k_q == K_LAST) begin
            load_mem_q <= 1'b0;
            state_q    <= ST_WAIT_DONE;
`ifdef RX_OCM_LOADER_TIMEOUT_EN
            wd_q       <= '0;
`endif
          end else begin
            k_q        <= k_next;
            location_q <= 8'(loc_next);
            mem_data_q <= tap_q[burst_sel];
          end
        end
        ST_WAIT_DONE: begin
          if (done_wait_i) begin
            state_q <= ST_STREAM;
`ifdef RX_OCM_LOADER_TIMEOUT_EN
          end else if (wd_q == WD_LAST) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else begin
            wd_q <= wd_q + 7'd1;
`endif
          end
        end
        ST_STREAM: begin
          if (rd_cnt_q == SMP_CNT) begin
            state_q <= ST_DRAIN;
          end else if (!hold_i) begin
            mem_rd_q    <= 1'b1;
            rd_sample_q <= 1'b1;
            mem_addr_q  <= BASE_ADDR + MEM_ADDR_WIDTH'(rd_cnt_q);
            rd_cnt_q    <= rd_cnt_q + CNT_W'(1);
            if (rd_cnt_q == SMP_LAST) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Done once the last issued read has left the latency pipe
          if (!mem_rd_q && pipe_empty) begin
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Register returning sample data towards the DFE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sig_q       <= '0;
      sig_valid_q <= 1'b0;
    end else begin
      sig_valid_q <= pipe_valid & pipe_sample;
      if (pipe_valid && pipe_sample) sig_q <= mem_rdata_i[SIGNAL_RESOLUTION-1:0];
    end
  end

  assign mem_rd_o          = mem_rd_q;
  assign mem_addr_o        = mem_addr_q;
  assign load_mem_o        = load_mem_q;
  assign location_o        = location_q;
  assign mem_data_o        = mem_data_q;
  assign signal_in_o       = sig_q;
  assign signal_in_valid_o = sig_valid_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
`ifdef RX_OCM_LOADER_TIMEOUT_EN
  assign error_o           = error_q;
`else
  assign error_o           = 1'b0;
`endif

endmodule

// File: tb/tb_rx_ocm_loader.sv
// tb/tb_rx_ocm_loader.sv - directed self-checking bench for rx_ocm_loader
module tb_rx_ocm_loader;

  localparam int P = 5;
  localparam int R = 2;
  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        hold;
  logic        mem_rd_o;
  logic [11:0] mem_addr_o;
  logic [63:0] mem_rdata;
  logic        load_mem_o;
  logic [7:0]  location_o;
  logic [63:0] mem_data_o;
  logic        done_wait;
  logic [7:0]  signal_in_o;
  logic        signal_in_valid_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  rx_ocm_loader #(
    .PULSE_RESPONSE_LENGTH (P),
    .SIGNAL_RESOLUTION     (8),
    .MEM_ADDR_WIDTH        (12),
    .NUM_SAMPLES           (N),
    .READ_LATENCY          (R)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .hold_i            (hold),
    .mem_rd_o          (mem_rd_o),
    .mem_addr_o        (mem_addr_o),
    .mem_rdata_i       (mem_rdata),
    .load_mem_o        (load_mem_o),
    .location_o        (location_o),
    .mem_data_o        (mem_data_o),
    .done_wait_i       (done_wait),
    .signal_in_o       (signal_in_o),
    .signal_in_valid_o (signal_in_valid_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .error_o           (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // OCM model: fixed two-cycle read latency
  logic [63:0] ocm [16];
  logic [11:0] a0, a1;
  always @(posedge clk) begin
    a0 <= mem_addr_o;
    a1 <= a0;
  end
  assign mem_rdata = ocm[a1[3:0]];

  // DFE model: writes each word to the previous strobe's location
  logic [63:0] dfe_tap [P];
  logic [7:0]  prev_loc;
  int          dfe_cnt;
  logic        dfe_mute;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dfe_cnt   <= 0;
      done_wait <= 1'b0;
      prev_loc  <= '0;
    end else if (load_mem_o) begin
      if (dfe_cnt > 0 && prev_loc < P) dfe_tap[prev_loc] <= mem_data_o;
      prev_loc <= location_o;
      dfe_cnt  <= dfe_cnt + 1;
      if (dfe_cnt + 1 == P + 2 && !dfe_mute) done_wait <= 1'b1;
    end
  end

  // Activity logs sampled mid-cycle
  logic [7:0] loc_log [16];
  logic [7:0] smp_log [16];
  int         vcyc [16];
  int load_cnt, rd_cnt, vcnt, done_cnt;
  int first_rd_cyc, last_rd_cyc, first_load_cyc, last_load_cyc, done_cyc;
  logic done_err;
  always @(negedge clk) begin
    if (load_mem_o) begin
      if (load_cnt < 16) loc_log[load_cnt] = location_o;
      if (load_cnt == 0) first_load_cyc = cyc;
      last_load_cyc = cyc;
      load_cnt++;
    end
    if (mem_rd_o) begin
      if (rd_cnt == 0) first_rd_cyc = cyc;
      last_rd_cyc = cyc;
      rd_cnt++;
    end
    if (signal_in_valid_o) begin
      if (vcnt < 16) begin
        smp_log[vcnt] = signal_in_o;
        vcyc[vcnt]    = cyc;
      end
      vcnt++;
    end
    if (done_o) begin
      done_cyc = cyc;
      done_err = error_o;
      done_cnt++;
    end
  end

  task automatic clear_logs();
    load_cnt = 0; rd_cnt = 0; vcnt = 0; done_cnt = 0;
    first_rd_cyc = 0; last_rd_cyc = 0; first_load_cyc = 0; last_load_cyc = 0;
    done_cyc = 0; done_err = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_mem_rd"},   mem_rd_o,          1'b0);
    chk({pfx, "_load_mem"}, load_mem_o,        1'b0);
    chk({pfx, "_valid"},    signal_in_valid_o, 1'b0);
    chk({pfx, "_busy"},     busy_o,            1'b0);
    chk({pfx, "_done"},     done_o,            1'b0);
    chk({pfx, "_error"},    error_o,           1'b0);
    chk({pfx, "_mem_addr"}, mem_addr_o,        12'h0);
    chk({pfx, "_location"}, location_o,        8'h0);
    chk({pfx, "_mem_data"}, mem_data_o,        64'h0);
    chk({pfx, "_signal"},   signal_in_o,       8'h0);
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done_o, 1'b1);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_samples(input string pfx);
    chk({pfx, "_vcnt"}, vcnt, 4);
    chk({pfx, "_samples"}, {smp_log[0], smp_log[1], smp_log[2], smp_log[3]}, 32'h10F07F80);
    chk({pfx, "_done_lat"}, done_cyc - last_rd_cyc, R + 2);
    chk({pfx, "_done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] taps [P];
    taps[0] = 64'h0040_0001; taps[1] = 64'h0010_0000; taps[2] = 64'h0008_0000;
    taps[3] = 64'h0004_0000; taps[4] = 64'h0002_0000;
    for (int i = 0; i < 16; i++) ocm[i] = 64'hBAD0_0000_0000_0000 | 64'(i);
    for (int i = 0; i < P; i++) ocm[i] = taps[i];
    ocm[5] = 64'hDEAD_0000_0000_0010;
    ocm[6] = 64'hDEAD_0000_0000_00F0;
    ocm[7] = 64'hDEAD_0000_0000_007F;
    ocm[8] = 64'hDEAD_0000_0000_0080;
    for (int i = 0; i < P; i++) dfe_tap[i] = '0;
    rst = 1'b0; start = 1'b0; hold = 1'b0; dfe_mute = 1'b0;
    clear_logs();

    #1 rst = 1'b1;
    #1 check_reset("rst0");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Run 1: tap fetch, burst, stream
    clear_logs();
    pulse_start();
    chk("r1_first_rd", mem_rd_o, 1'b1);
    chk("r1_first_addr", mem_addr_o, 12'h0);
    chk("r1_busy", busy_o, 1'b1);
    wait_done("r1_done_seen", 300);
    chk("r1_load_cnt", load_cnt, P + 2);
    chk("r1_loc_seq", {loc_log[0], loc_log[1], loc_log[2], loc_log[3], loc_log[4], loc_log[5], loc_log[6]},
        56'h00_01_02_03_04_04_04);
    for (int j = 0; j < P; j++) chk($sformatf("r1_dfe_tap%0d", j), dfe_tap[j], taps[j]);
    chk("r1_load_rise", first_load_cyc - first_rd_cyc, P + R);
    check_samples("r1");
    chk("r1_consecutive", vcyc[3] - vcyc[0], 3);
    chk("r1_run_len", done_cyc - first_rd_cyc + 1, (P + R) + (P + 2) + 1 + N + R + 3);
    chk("r1_busy_end", busy_o, 1'b0);
    chk("r1_error", error_o, 1'b0);

    // Run 2: taps already loaded
    clear_logs();
    pulse_start();
    chk("r2_first_rd", mem_rd_o, 1'b1);
    chk("r2_first_addr", mem_addr_o, 12'(P));
    wait_done("r2_done_seen", 100);
    chk("r2_load_cnt", load_cnt, 0);
    check_samples("r2");

    // Run 3: hold for three cycles mid-stream
    clear_logs();
    pulse_start();
    @(negedge clk);
    hold = 1'b1;
    repeat (3) @(negedge clk);
    hold = 1'b0;
    wait_done("r3_done_seen", 100);
    check_samples("r3");
    chk("r3_gaps", {8'(vcyc[1] - vcyc[0]), 8'(vcyc[2] - vcyc[1]), 8'(vcyc[3] - vcyc[2])}, 24'h01_04_01);

    // Run 4: reset while sample reads are in flight
    clear_logs();
    pulse_start();
    repeat (2) @(negedge clk);
    chk("r4_in_flight", mem_rd_o, 1'b1);
    rst = 1'b1;
    #1 check_reset("r4_rst");
    clear_logs();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("r4_no_valid", vcnt, 0);
    chk("r4_no_done", done_cnt, 0);
    chk("r4_no_rd", rd_cnt, 0);

    // Run 5: DFE never answers
    dfe_mute = 1'b1;
    clear_logs();
    pulse_start();
`ifdef RX_OCM_LOADER_TIMEOUT_EN
    wait_done("r5_done_seen", 400);
    chk("r5_load_cnt", load_cnt, P + 2);
    chk("r5_timeout_lat", done_cyc - last_load_cyc, 65);
    chk("r5_err_at_done", done_err, 1'b1);
    chk("r5_no_valid", vcnt, 0);
    chk("r5_err_sticky", error_o, 1'b1);
    pulse_start();
    chk("r5_err_clear", error_o, 1'b0);
`else
    repeat (120) @(negedge clk);
    chk("r5_load_cnt", load_cnt, P + 2);
    chk("r5_still_busy", busy_o, 1'b1);
    chk("r5_no_done", done_cnt, 0);
    chk("r5_error", error_o, 1'b0);
    chk("r5_no_valid", vcnt, 0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
